// File: rtl/msi_irq_scheduler.sv
// Round-robin MSI scheduler: collects per-vector interrupt requests and issues
// them one at a time to the PCIe core's MSI interface, backing off after a fail.
module msi_irq_scheduler #(
  parameter int IRQ_COUNT      = 32,
  parameter int BACKOFF_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IRQ_COUNT-1:0] irq,
  input  logic [3:0]           cfg_interrupt_msi_enable,
  input  logic [11:0]          cfg_interrupt_msi_mmenable,
  output logic [31:0]          cfg_interrupt_msi_int,
  input  logic                 cfg_interrupt_msi_sent,
  input  logic                 cfg_interrupt_msi_fail,
  output logic [3:0]           cfg_interrupt_msi_select,
  output logic [31:0]          cfg_interrupt_msi_pending_status,
  output logic                 cfg_interrupt_msi_pending_status_data_enable,
  output logic [3:0]           cfg_interrupt_msi_pending_status_function_num,
  output logic [2:0]           cfg_interrupt_msi_attr,
  output logic                 cfg_interrupt_msi_tph_present,
  output logic [1:0]           cfg_interrupt_msi_tph_type,
  output logic [8:0]           cfg_interrupt_msi_tph_st_tag,
  output logic [3:0]           cfg_interrupt_msi_function_number,
  output logic                 busy,
  output logic [15:0]          fail_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_BACKOFF = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IRQ_COUNT-1:0] pending_q, pending_d;
  logic [4:0]           last_grant_q, last_grant_d;
  logic [4:0]           in_flight_q, in_flight_d;
  logic [31:0]          msi_int_q, msi_int_d;
  logic [7:0]           backoff_q, backoff_d;
  logic [15:0]          fail_count_q, fail_count_d;

  logic [31:0]          allow_mask_s;
  logic [31:0]          eligible_s;
  logic                 found_s;
  logic [4:0]           pick_s;
  logic [31:0]          pick_onehot_s;
  logic                 unused_cfg_s;

  assign unused_cfg_s = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

  // Vectors below 2^mmenable (capped at 32) are allowed while MSI is enabled.
  always_comb begin
    case (cfg_interrupt_msi_mmenable[2:0])
      3'd0:    allow_mask_s = 32'h0000_0001;
      3'd1:    allow_mask_s = 32'h0000_0003;
      3'd2:    allow_mask_s = 32'h0000_000F;
      3'd3:    allow_mask_s = 32'h0000_00FF;
      3'd4:    allow_mask_s = 32'h0000_FFFF;
      default: allow_mask_s = 32'hFFFF_FFFF;
    endcase
    eligible_s = 32'd0;
    if (cfg_interrupt_msi_enable[0]) begin
      eligible_s[IRQ_COUNT-1:0] = pending_q & allow_mask_s[IRQ_COUNT-1:0];
    end else begin
      eligible_s = 32'd0;
    end
  end

  // Round-robin search beginning one past the last vector that was sent.
  always_comb begin
    logic [5:0] idx;
    found_s = 1'b0;
    pick_s  = 5'd0;
    idx     = 6'd0;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      idx = {1'b0, last_grant_q} + 6'd1 + 6'(i);
      if (idx >= 6'(IRQ_COUNT)) begin
        idx = idx - 6'(IRQ_COUNT);
      end else begin
        idx = idx;
      end
      if (!found_s && eligible_s[idx[4:0]]) begin
        found_s = 1'b1;
        pick_s  = idx[4:0];
      end else begin
        found_s = found_s;
      end
    end
    pick_onehot_s = 32'd1 << pick_s;
  end

  // Scheduler next-state: grant in IDLE, wait for the core's verdict, back off on fail.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    last_grant_d = last_grant_q;
    in_flight_d  = in_flight_q;
    msi_int_d    = msi_int_q;
    backoff_d    = backoff_q;
    fail_count_d = fail_count_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          pending_d   = pending_q & ~pick_onehot_s[IRQ_COUNT-1:0];
          msi_int_d   = pick_onehot_s;
          in_flight_d = pick_s;
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cfg_interrupt_msi_sent) begin
          msi_int_d    = 32'd0;
          last_grant_d = in_flight_q;
          state_d      = S_IDLE;
        end else if (cfg_interrupt_msi_fail) begin
          msi_int_d    = 32'd0;
          pending_d    = pending_q | msi_int_q[IRQ_COUNT-1:0];
          fail_count_d = (fail_count_q == 16'hFFFF) ? fail_count_q : fail_count_q + 16'd1;
          backoff_d    = 8'(BACKOFF_CYCLES);
          state_d      = S_BACKOFF;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_BACKOFF: begin
        if (backoff_q <= 8'd1) begin
          backoff_d = 8'd0;
          state_d   = S_IDLE;
        end else begin
          backoff_d = backoff_q - 8'd1;
        end
      end
      default: begin
        msi_int_d = 32'd0;
        state_d   = S_IDLE;
      end
    endcase
    pending_d = pending_d | irq;
  end

  // State registers with synchronous reset; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      last_grant_q <= 5'(IRQ_COUNT - 1);
      in_flight_q  <= 5'd0;
      msi_int_q    <= 32'd0;
      backoff_q    <= 8'd0;
      fail_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      in_flight_q  <= in_flight_d;
      msi_int_q    <= msi_int_d;
      backoff_q    <= backoff_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign cfg_interrupt_msi_int                         = msi_int_q;
  assign busy                                          = (state_q != S_IDLE);
  assign fail_count                                    = fail_count_q;
  assign cfg_interrupt_msi_select                      = 4'd0;
  assign cfg_interrupt_msi_pending_status              = 32'd0;
  assign cfg_interrupt_msi_pending_status_data_enable  = 1'b0;
  assign cfg_interrupt_msi_pending_status_function_num = 4'd0;
  assign cfg_interrupt_msi_attr                        = 3'd0;
  assign cfg_interrupt_msi_tph_present                 = 1'b0;
  assign cfg_interrupt_msi_tph_type                    = 2'd0;
  assign cfg_interrupt_msi_tph_st_tag                  = 9'd0;
  assign cfg_interrupt_msi_function_number             = 4'd0;

endmodule

// File: tb/tb_msi_irq_scheduler.sv
// Bench for msi_irq_scheduler: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level model of the scheduling rules.
module tb_msi_irq_scheduler;
  localparam int NIRQ = 24;
  localparam int BACK = 16;

  logic            clk = 1'b0;
  logic            rst_r;
  logic [NIRQ-1:0] irq_r;
  logic [3:0]      en_r;
  logic [11:0]     mm_r;
  logic            sent_r, fail_r;
  logic [31:0]     msi_int;
  logic [3:0]      sel, pnd_fn, fn_num;
  logic [31:0]     pnd_st;
  logic            pnd_de, tph_p, busy;
  logic [2:0]      attr;
  logic [1:0]      tph_t;
  logic [8:0]      tph_tag;
  logic [15:0]     fail_count;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  bit m_pend[NIRQ];
  int m_fly, m_wait, m_last, m_fails;

  always #5 clk = ~clk;

  msi_irq_scheduler #(.IRQ_COUNT(NIRQ), .BACKOFF_CYCLES(BACK)) dut (
    .clk(clk), .rst(rst_r), .irq(irq_r),
    .cfg_interrupt_msi_enable(en_r), .cfg_interrupt_msi_mmenable(mm_r),
    .cfg_interrupt_msi_int(msi_int),
    .cfg_interrupt_msi_sent(sent_r), .cfg_interrupt_msi_fail(fail_r),
    .cfg_interrupt_msi_select(sel),
    .cfg_interrupt_msi_pending_status(pnd_st),
    .cfg_interrupt_msi_pending_status_data_enable(pnd_de),
    .cfg_interrupt_msi_pending_status_function_num(pnd_fn),
    .cfg_interrupt_msi_attr(attr),
    .cfg_interrupt_msi_tph_present(tph_p),
    .cfg_interrupt_msi_tph_type(tph_t),
    .cfg_interrupt_msi_tph_st_tag(tph_tag),
    .cfg_interrupt_msi_function_number(fn_num),
    .busy(busy), .fail_count(fail_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one cycle using the inputs that were applied in it.
  task automatic model_step();
    int allowed;
    bit found;
    if (rst_r) begin
      for (int v = 0; v < NIRQ; v++) m_pend[v] = 1'b0;
      m_fly = -1; m_wait = 0; m_last = NIRQ - 1; m_fails = 0;
    end else begin
      if (m_fly >= 0) begin
        if (sent_r) begin
          m_last = m_fly;
          m_fly  = -1;
        end else if (fail_r) begin
          m_pend[m_fly] = 1'b1;
          if (m_fails < 65535) m_fails++;
          m_wait = BACK;
          m_fly  = -1;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else begin
        allowed = (mm_r[2:0] >= 3'd5) ? 32 : (1 << mm_r[2:0]);
        found = 1'b0;
        for (int i = 1; i <= NIRQ; i++) begin
          int v;
          v = (m_last + i) % NIRQ;
          if (!found && m_pend[v] && en_r[0] && v < allowed) begin
            found = 1'b1;
            m_fly = v;
            m_pend[v] = 1'b0;
          end
        end
      end
      for (int v = 0; v < NIRQ; v++) if (irq_r[v]) m_pend[v] = 1'b1;
    end
  endtask

  task automatic tick();
    logic [31:0] exp_msi;
    @(posedge clk);
    #1;
    model_step();
    exp_msi = (m_fly >= 0) ? (32'd1 << m_fly) : 32'd0;
    chk("msi_int", msi_int, exp_msi);
    chk("busy", {31'd0, busy}, {31'd0, (m_fly >= 0 || m_wait > 0)});
    chk("fail_count", {16'd0, fail_count}, m_fails);
  endtask

  task automatic pulse(input int v);
    irq_r = '0;
    irq_r[v] = 1'b1;
    tick();
    irq_r = '0;
  endtask

  task automatic send();
    sent_r = 1'b1;
    tick();
    sent_r = 1'b0;
  endtask

  // Tick until the DUT asserts an MSI (bounded); returns ticks spent.
  task automatic wait_msi(output int n);
    n = 0;
    while (msi_int == 32'd0 && n < 40) begin
      tick();
      n++;
    end
    chk("wait_msi", {31'd0, (msi_int != 32'd0)}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, z, cnt;
    rst_r = 1'b1; irq_r = '0; en_r = 4'h1; mm_r = 12'd5; sent_r = 1'b0; fail_r = 1'b0;
    tick(); tick();
    chk("rst_msi", msi_int, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("const_zero", {sel, pnd_st[27:0]} | {pnd_st[31:28], pnd_fn, pnd_de, attr, tph_p, tph_t,
        tph_tag, fn_num, 8'd0}, 32'd0);
    rst_r = 1'b0;
    repeat (3) tick();

    // single vector, sent four cycles after assertion
    pulse(3);
    chk("r030_lat1", msi_int, 32'd0);
    tick();
    chk("r030_assert", msi_int, 32'h8);
    repeat (3) tick();
    chk("r030_hold", msi_int, 32'h8);
    send();
    chk("r030_done", msi_int, 32'd0);
    chk("r030_busy", {31'd0, busy}, 32'd0);

    // three simultaneous requests issued in order with one idle cycle between
    irq_r = NIRQ'(7);
    tick();
    irq_r = '0;
    for (int k = 0; k < 3; k++) begin
      wait_msi(n);
      if (k > 0) chk("r031_gap", n, 1);
      chk("r031_order", msi_int, 32'd1 << k);
      tick();
      send();
    end

    // fail then backoff: 16 backoff + 1 idle cycle with msi low
    pulse(7);
    wait_msi(n);
    chk("r032_first", msi_int, 32'h80);
    fail_r = 1'b1;
    tick();
    fail_r = 1'b0;
    z = 0;
    while (msi_int == 32'd0 && z < 40) begin
      z++;
      tick();
    end
    chk("r032_gap", z, 17);
    chk("r032_fc", {16'd0, fail_count}, 32'd1);
    chk("r032_reissue", msi_int, 32'h80);
    send();

    // vector blocked by mmenable until the window widens
    mm_r = 12'd0;
    pulse(4);
    repeat (5) tick();
    chk("r033_blocked", msi_int, 32'd0);
    mm_r = 12'd3;
    tick(); tick();
    chk("r033_issue", msi_int, 32'h10);
    send();
    mm_r = 12'd5;

    // re-request during issue, then coalescing of repeated requests
    pulse(2);
    wait_msi(n);
    chk("r034_first", msi_int, 32'h4);
    pulse(2);
    send();
    wait_msi(n);
    chk("r034_again", msi_int, 32'h4);
    send();
    en_r = 4'h0;
    repeat (3) begin
      pulse(2);
      tick();
    end
    en_r = 4'h1;
    wait_msi(n);
    chk("r034_once", msi_int, 32'h4);
    send();
    cnt = 0;
    repeat (10) begin
      tick();
      if (msi_int != 32'd0) cnt++;
    end
    chk("r034_coalesce", cnt, 0);

    // reset in the middle of an issue discards the request
    pulse(5);
    wait_msi(n);
    rst_r = 1'b1;
    tick();
    rst_r = 1'b0;
    chk("r035_msi", msi_int, 32'd0);
    chk("r035_busy", {31'd0, busy}, 32'd0);
    cnt = 0;
    repeat (10) begin
      tick();
      if (msi_int != 32'd0) cnt++;
    end
    chk("r035_noreissue", cnt, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      irq_r  = ($urandom_range(0, 5) == 0) ? NIRQ'($urandom) : '0;
      sent_r = ($urandom_range(0, 3) == 0);
      fail_r = ($urandom_range(0, 6) == 0);
      rst_r  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) mm_r = 12'($urandom);
      if ($urandom_range(0, 49) == 0) en_r = {3'($urandom), 1'($urandom_range(0, 9) != 0)};
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/msi_irq_scheduler.md
MSI_IRQ_SCHEDULER -- requirements
Module: msi_irq_scheduler

Interface
REQ-001 SHALL have parameter IRQ_COUNT, default 32, number of interrupt request lines, legal range 1..32.
REQ-002 SHALL have parameter BACKOFF_CYCLES, default 16, idle cycles after an MSI fail before re-arbitration, legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock, the PCIe user clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port irq  input  IRQ_COUNT  per-vector request; each cycle high counts as one request event.
REQ-006 SHALL have port cfg_interrupt_msi_enable  input  4  MSI enable per function; bit 0 used.
REQ-007 SHALL have port cfg_interrupt_msi_mmenable  input  12  multiple-message enable; bits [2:0] used.
REQ-008 SHALL have port cfg_interrupt_msi_int  output  32  one-hot MSI vector request to PCIe core.
REQ-009 SHALL have port cfg_interrupt_msi_sent  input  1  core accepted and sent the MSI.
REQ-010 SHALL have port cfg_interrupt_msi_fail  input  1  core rejected the MSI.
REQ-011 SHALL have outputs cfg_interrupt_msi_select (4), cfg_interrupt_msi_pending_status (32), cfg_interrupt_msi_pending_status_data_enable (1), cfg_interrupt_msi_pending_status_function_num (4), cfg_interrupt_msi_attr (3), cfg_interrupt_msi_tph_present (1), cfg_interrupt_msi_tph_type (2), cfg_interrupt_msi_tph_st_tag (9), cfg_interrupt_msi_function_number (4), all constant zero.
REQ-012 SHALL have port busy  output  1  high when state is not IDLE.
REQ-013 SHALL have port fail_count  output  16  saturating count of fail responses.

Function
REQ-014 SHALL hold a pending register, one bit per vector; irq[v] high sets pending[v] on the next edge.
REQ-015 SHALL define allowed = 1 << mmenable[2:0] (1..32, capped at 32); vector v is eligible when pending[v], enable[0]=1 and v < allowed.
REQ-016 SHALL keep ineligible pending bits set indefinitely; they become eligible when enable/mmenable change.
REQ-017 SHALL implement states IDLE, ISSUE, BACKOFF.
REQ-018 IDLE: when any vector is eligible, SHALL select one by round-robin, starting search at last_grant+1 with wrap from IRQ_COUNT-1 to 0, clear its pending bit, register cfg_interrupt_msi_int = one-hot(selected), enter ISSUE on the same edge.
REQ-019 ISSUE: SHALL hold cfg_interrupt_msi_int unchanged until sent or fail, regardless of enable/mmenable changes.
REQ-020 ISSUE + sent: SHALL drive cfg_interrupt_msi_int to zero on the next edge, update last_grant, return to IDLE.
REQ-021 ISSUE + fail: SHALL drive cfg_interrupt_msi_int to zero, re-set pending for the in-flight vector, increment fail_count (saturating at 0xFFFF), load backoff counter with BACKOFF_CYCLES, enter BACKOFF.
REQ-022 sent and fail in the same cycle SHALL be treated as sent.
REQ-023 BACKOFF: SHALL decrement counter each cycle and enter IDLE when it reaches zero; no issue occurs in BACKOFF.
REQ-024 irq[v] asserted while v is in flight SHALL set pending[v] again, producing a later MSI; multiple events on an already-pending vector coalesce into one.
REQ-025 Minimum spacing between consecutive MSI assertions SHALL be two cycles (one IDLE cycle).
REQ-026 Latency: irq pulse at cycle N with scheduler idle and eligible SHALL give cfg_interrupt_msi_int asserted from cycle N+2.
REQ-027 cfg_interrupt_msi_int bits at and above IRQ_COUNT SHALL always be zero.

Reset
REQ-028 On rst: state IDLE, pending all zero, last_grant = IRQ_COUNT-1 (so first search starts at vector 0), cfg_interrupt_msi_int zero, backoff counter zero, fail_count zero, busy zero.
REQ-029 rst asserted during ISSUE or BACKOFF SHALL abort immediately; the in-flight request is discarded, not re-queued.

Verification
REQ-030 enable=1, mmenable=5, irq[3] pulse at cycle 10, sent 4 cycles after assert -> msi_int=0x00000008 from cycle 12 until sent, then zero, busy low.
REQ-031 irq[0],irq[1],irq[2] pulsed together, sent 1 cycle after each assert -> MSIs issued in order 0x1, 0x2, 0x4, each separated by one idle cycle.
REQ-032 irq[7] issued, fail returned, BACKOFF_CYCLES=16 -> msi_int zero, fail_count=1, re-issue of 0x80 exactly 17 cycles after fail (16 BACKOFF + 1 IDLE).
REQ-033 mmenable=0, irq[4] pulse -> no MSI; then mmenable=3 -> 0x10 issued two cycles later.
REQ-034 irq[2] pulsed again during its ISSUE, sent -> second 0x4 MSI issued; irq[2] pulsed 3 times while pending -> only one MSI.
REQ-035 rst asserted mid-ISSUE -> next cycle msi_int=0, pending=0, busy=0; no re-issue.
